// File: rtl/uart_tx_pkg.sv
// ============================================================================
// Module      : uart_tx_pkg
// Description : Shared definitions for the UART transmit path. Holds the
//               frame state encoding, the default clock and line rates, and
//               helpers that derive the baud divisor and its counter width.
//               The receive side is expected to import the same package.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_pkg;

  // Frame sequencer states (2-bit encoding shared with the receiver).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int DEF_CLK_FREQ  = 27_000_000;
  localparam int DEF_BAUD_RATE = 115_200;

  // System clocks per line bit; integer truncation is intentional.
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Width of a counter that runs 0..cpb-1.
  function automatic int baud_cnt_width(input int cpb);
    return $clog2(cpb);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_if.sv
// ============================================================================
// Module      : uart_tx_if
// Description : Byte-in / serial-out bundle of the UART transmitter.
//               master : byte producer (drives tx_data, tx_valid)
//               slave  : transmitter  (drives tx_ready, tx_busy, tx_done, tx)
// Ports       : tx_data  - byte to send, sampled only on accept
//               tx_valid - tx_data is valid
//               tx_ready - transmitter idle, can accept
//               tx_busy  - frame in progress
//               tx_done  - one-cycle pulse at frame end
//               tx       - serial line, idle high
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 tx;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_busy, tx_done, tx
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_busy, tx_done, tx
  );

endinterface

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ============================================================================
// Module      : uart_baud_gen
// Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and flags the
//               terminal count; wraps on its own and is held at zero while
//               clear is high.
// Ports       : clk   - system clock
//               rst_n - asynchronous reset, active low
//               clear - hold counter at zero
//               tick  - counter is at terminal count this cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_gen
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int               CNT_W = baud_cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || (cnt_q == TERM)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == TERM);

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter. Accepts one byte per valid/ready handshake
//               and sends start bit, DATA_BITS data bits LSB first, then
//               STOP_BITS stop bits. All outputs are registered; the line
//               idles high, including while reset is asserted.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous reset, active low
//               bus   - uart_tx_if.slave (tx_data, tx_valid in;
//                       tx_ready, tx_busy, tx_done, tx out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ  = DEF_CLK_FREQ,
  parameter int BAUD_RATE = DEF_BAUD_RATE,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus
);

  localparam int               CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int               IDX_W        = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST    = 1'(STOP_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_chk_baud
      $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_chk_data
      $error("uart_tx: DATA_BITS must be 5..9");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_chk_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  uart_state_e          state_q, state_d;
  logic [IDX_W-1:0]     idx_q,   idx_d;
  logic                 stop_q,  stop_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 tx_q,    tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q,  busy_d;
  logic                 done_q,  done_d;

  logic w_clear;
  logic w_tick;

  // Holding the counter at zero in IDLE makes the START bit last exactly
  // CLKS_PER_BIT cycles from the accept edge; afterwards the counter wraps
  // on its own at each bit boundary.
  assign w_clear = (state_q == ST_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(w_clear),
    .tick (w_tick)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.tx_valid && ready_q) begin
          shreg_d = bus.tx_data;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) begin
          tx_d    = shreg_q[0];
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == LAST_IDX) begin
            tx_d    = 1'b1;
            stop_d  = 1'b0;
            state_d = ST_STOP;
          end else begin
            // tx is registered, so load the bit that becomes shreg[0].
            tx_d  = shreg_q[1];
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (stop_q == STOP_LAST) begin
            tx_d    = 1'b1;
            ready_d = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = ~ready_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx       = tx_q;
  assign bus.tx_ready = ready_q;
  assign bus.tx_busy  = busy_q;
  assign bus.tx_done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module      : tb_uart_tx
// Description : Directed testbench for uart_tx at 10 clocks per bit. Two
//               instances: one with a single stop bit, one with two. A line
//               decoder per instance recovers bytes from the serial output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

  localparam int CPB = 10;

  logic clk;
  logic rst_n;
  int   cyc   = 0;
  int   done1 = 0;
  int   done2 = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [15:0] rxq1[$];
  logic [15:0] rxq2[$];
  int          rxt1[$];
  int          rxt2[$];

  uart_tx_if #(.DATA_BITS(8)) u_if1 ();
  uart_tx_if #(.DATA_BITS(8)) u_if2 ();

  uart_tx #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .STOP_BITS(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(u_if1)
  );

  uart_tx #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .STOP_BITS(2)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(u_if2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (u_if1.tx_done === 1'b1) done1 <= done1 + 1;
    if (u_if2.tx_done === 1'b1) done2 <= done2 + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic line_of(input int which);
    return (which == 0) ? u_if1.tx : u_if2.tx;
  endfunction

  function automatic logic ready_of(input int which);
    return (which == 0) ? u_if1.tx_ready : u_if2.tx_ready;
  endfunction

  // Line decoder: entered at the first falling-edge sample of a start bit,
  // samples each bit near its middle. Bit 8 of the result flags a bad
  // start or stop bit.
  task automatic rx_frame(input int which, input int sb, output logic [15:0] res);
    logic [7:0] d;
    logic       ferr;
    d    = '0;
    ferr = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    if (line_of(which) !== 1'b0) ferr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      d[i] = line_of(which);
    end
    for (int s = 0; s < sb; s++) begin
      repeat (CPB) @(negedge clk);
      if (line_of(which) !== 1'b1) ferr = 1'b1;
    end
    res = {7'd0, ferr, d};
  endtask

  initial begin : mon1
    logic [15:0] r;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && u_if1.tx === 1'b0) begin
        rxt1.push_back(cyc);
        rx_frame(0, 1, r);
        rxq1.push_back(r);
      end
    end
  end

  initial begin : mon2
    logic [15:0] r;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && u_if2.tx === 1'b0) begin
        rxt2.push_back(cyc);
        rx_frame(1, 2, r);
        rxq2.push_back(r);
      end
    end
  end

  function automatic logic [31:0] q1_at(input int idx);
    return (rxq1.size() > idx) ? 32'(rxq1[idx]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] q2_at(input int idx);
    return (rxq2.size() > idx) ? 32'(rxq2[idx]) : 32'hDEAD;
  endfunction

  // Called at a sample point; accept happens on the next edge.
  task automatic send(input int which, input logic [7:0] d, output int e);
    if (which == 0) begin
      u_if1.tx_data = d; u_if1.tx_valid = 1'b1;
    end else begin
      u_if2.tx_data = d; u_if2.tx_valid = 1'b1;
    end
    tick();
    e = cyc;
    u_if1.tx_valid = 1'b0;
    u_if2.tx_valid = 1'b0;
  endtask

  task automatic wait_ready(input int which, input string tag, output int t);
    int n;
    n = 0;
    while (ready_of(which) !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    t = cyc;
    check_eq(tag, 32'(ready_of(which)), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          e, e2, t, base, errs, rerrs;
    logic [7:0]  d;
    logic        exp;

    rst_n = 1'b1;
    u_if1.tx_valid = 1'b0; u_if1.tx_data = '0;
    u_if2.tx_valid = 1'b0; u_if2.tx_data = '0;

    // ---- 1: reset state, before any clock edge and mid-clock ----
    #1 rst_n = 1'b0;
    #1;
    check_eq("t1_tx",    32'(u_if1.tx),       32'd1);
    check_eq("t1_ready", 32'(u_if1.tx_ready), 32'd1);
    check_eq("t1_busy",  32'(u_if1.tx_busy),  32'd0);
    check_eq("t1_done",  32'(u_if1.tx_done),  32'd0);
    repeat (3) @(posedge clk);
    #3;
    check_eq("t1_tx_mid",    32'(u_if1.tx),       32'd1);
    check_eq("t1_ready_mid", 32'(u_if1.tx_ready), 32'd1);
    check_eq("t1_tx2_mid",   32'(u_if2.tx),       32'd1);
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();
    check_eq("t1_idle_ready", 32'(u_if1.tx_ready), 32'd1);

    // ---- 2: 0x55, one-cycle valid ----
    base = done1;
    d = 8'h55;
    send(0, d, e);
    errs = 0; rerrs = 0;
    for (int k = 0; k < 100; k++) begin
      if (k < 10)      exp = 1'b0;
      else if (k < 90) exp = d[(k - 10) / 10];
      else             exp = 1'b1;
      if (u_if1.tx !== exp) errs++;
      if (u_if1.tx_ready !== 1'b0 || u_if1.tx_busy !== 1'b1) rerrs++;
      tick();
    end
    check_eq("t2_wave_errs",  32'(errs),          32'd0);
    check_eq("t2_busy_errs",  32'(rerrs),         32'd0);
    check_eq("t2_ready_100",  32'(u_if1.tx_ready), 32'd1);
    check_eq("t2_done_100",   32'(u_if1.tx_done),  32'd1);
    check_eq("t2_busy_low",   32'(u_if1.tx_busy),  32'd0);
    tick();
    check_eq("t2_done_pulse", 32'(u_if1.tx_done),  32'd0);
    check_eq("t2_done_count", 32'(done1 - base),   32'd1);
    check_eq("t2_rx_byte",    q1_at(rxq1.size() - 1), 32'h55);
    repeat (5) tick();

    // ---- 3: 0xA5 then 0x3C with valid held ----
    rxq1.delete(); rxt1.delete();
    base = done1;
    u_if1.tx_data = 8'hA5; u_if1.tx_valid = 1'b1;
    tick();
    e = cyc;
    check_eq("t3_acc1", 32'(u_if1.tx_ready), 32'd0);
    u_if1.tx_data = 8'h3C;
    wait_ready(0, "t3_ready1", t);
    check_eq("t3_ready1_lat", 32'(t - e), 32'd100);
    tick();
    check_eq("t3_acc2_ready", 32'(u_if1.tx_ready), 32'd0);
    check_eq("t3_start2_tx",  32'(u_if1.tx),       32'd0);
    check_eq("t3_start2_gap", 32'(cyc - e),        32'd101);
    e2 = cyc;
    u_if1.tx_valid = 1'b0;
    wait_ready(0, "t3_ready2", t);
    check_eq("t3_ready2_lat", 32'(t - e2), 32'd100);
    repeat (5) tick();
    check_eq("t3_rx_count", 32'(rxq1.size()), 32'd2);
    check_eq("t3_rx0",      q1_at(0), 32'hA5);
    check_eq("t3_rx1",      q1_at(1), 32'h3C);
    check_eq("t3_rx_gap",   (rxt1.size() > 1) ? 32'(rxt1[1] - rxt1[0]) : 32'hDEAD, 32'd101);
    check_eq("t3_done_cnt", 32'(done1 - base), 32'd2);

    // ---- 4: valid pulse mid-frame is ignored ----
    rxq1.delete(); rxt1.delete();
    base = done1;
    send(0, 8'h0F, e);
    repeat (34) tick();
    u_if1.tx_data = 8'hF0; u_if1.tx_valid = 1'b1;
    tick();
    u_if1.tx_valid = 1'b0;
    check_eq("t4_still_busy", 32'(u_if1.tx_ready), 32'd0);
    check_eq("t4_bit2",       32'(u_if1.tx),       32'd1);
    wait_ready(0, "t4_ready", t);
    check_eq("t4_ready_lat", 32'(t - e), 32'd100);
    repeat (5) tick();
    check_eq("t4_rx_count", 32'(rxq1.size()), 32'd1);
    check_eq("t4_rx0",      q1_at(0), 32'h0F);
    check_eq("t4_done_cnt", 32'(done1 - base), 32'd1);
    check_eq("t4_idle_tx",  32'(u_if1.tx), 32'd1);

    // ---- 5: reset in the middle of data bit 3 ----
    base = done1;
    send(0, 8'h00, e);
    repeat (45) tick();
    check_eq("t5_pre_rst_tx", 32'(u_if1.tx), 32'd0);
    #3 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_tx",    32'(u_if1.tx),       32'd1);
    check_eq("t5_rst_ready", 32'(u_if1.tx_ready), 32'd1);
    check_eq("t5_rst_busy",  32'(u_if1.tx_busy),  32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (120) tick();
    check_eq("t5_no_done", 32'(done1 - base), 32'd0);
    rxq1.delete(); rxt1.delete();
    base = done1;
    send(0, 8'h81, e);
    wait_ready(0, "t5_ready", t);
    check_eq("t5_ready_lat", 32'(t - e), 32'd100);
    repeat (5) tick();
    check_eq("t5_rx_count", 32'(rxq1.size()), 32'd1);
    check_eq("t5_rx0",      q1_at(0), 32'h81);
    check_eq("t5_done_cnt", 32'(done1 - base), 32'd1);

    // ---- 6: two stop bits ----
    rxq2.delete(); rxt2.delete();
    base = done2;
    send(1, 8'h00, e);
    errs = 0;
    for (int k = 0; k < 110; k++) begin
      exp = (k < 90) ? 1'b0 : 1'b1;
      if (u_if2.tx !== exp) errs++;
      tick();
    end
    check_eq("t6_wave_errs", 32'(errs),            32'd0);
    check_eq("t6_ready_110", 32'(u_if2.tx_ready),  32'd1);
    check_eq("t6_done_110",  32'(u_if2.tx_done),   32'd1);
    send(1, 8'hFF, e2);
    check_eq("t6_acc2", 32'(u_if2.tx_ready), 32'd0);
    wait_ready(1, "t6_ready2", t);
    check_eq("t6_ready2_lat", 32'(t - e2), 32'd110);
    repeat (5) tick();
    check_eq("t6_rx_count", 32'(rxq2.size()), 32'd2);
    check_eq("t6_rx0",      q2_at(0), 32'h00);
    check_eq("t6_rx1",      q2_at(1), 32'hFF);
    check_eq("t6_done_cnt", 32'(done2 - base), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
